// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmitter: FSM state encoding and the
//   clog2 helper used to size counters.
//
//   Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_e;

    // ceil(log2(n)), never less than 1 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-period counter. Counts CLK cycles and pulses bit_tick_o on the last
//   cycle of each bit period, then wraps to zero.
//
//   Ports:
//     CLK        - system clock
//     RSTn       - asynchronous active-low reset
//     clear_i    - holds the counter at zero (restarts the bit period)
//     bit_tick_o - one-cycle pulse on the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned P_CLKS_PER_BIT = 868
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam int unsigned CW = clog2(P_CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(P_CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_tick_o = ~clear_i && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter: start bit, P_DATA_BITS data bits LSB first, optional
//   even parity bit, one stop bit. A one-entry pending buffer lets a second
//   request queue behind the frame in flight; it follows with no idle gap.
//
//   Optional feature macro: UART_TX_PARITY_EN (even parity bit after DATA).
//
//   Ports:
//     CLK      - system clock, rising edge
//     RSTn     - asynchronous active-low reset
//     start    - single-cycle send request
//     data     - word to send, sampled when start is accepted
//     tx       - serial line, idle high
//     busy     - frame in progress or request pending
//     done     - one-cycle pulse after a frame's stop bit
//     overflow - one-cycle pulse when a request is dropped (buffer full)
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned P_CLKS_PER_BIT = 868,
    parameter int unsigned P_DATA_BITS    = 8
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   start,
    input  logic [P_DATA_BITS-1:0] data,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int unsigned IW = clog2(P_DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(P_DATA_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [P_DATA_BITS-1:0] frame_q, frame_d;
    logic [IW-1:0]          idx_q,   idx_d;
    logic [P_DATA_BITS-1:0] buf_q,   buf_d;
    logic                   full_q,  full_d;
    logic                   done_q,  done_d;
    logic                   ovf_q,   ovf_d;
    logic                   bit_tick;

    uart_baud_gen #(
        .P_CLKS_PER_BIT(P_CLKS_PER_BIT)
    ) u_baud (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .clear_i   (state_q == IDLE),
        .bit_tick_o(bit_tick)
    );

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        full_d  = full_q;
        done_d  = 1'b0;
        ovf_d   = 1'b0;

        // Requests arriving mid-frame (final stop cycle included) go to the
        // pending buffer, or are dropped if it is already occupied.
        if (state_q != IDLE && start) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                buf_d  = data;
                full_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_d = data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    done_d = 1'b1;
                    // A request on this very cycle with an empty buffer was
                    // just marked as buffered above; forward it straight into
                    // the next frame instead so both cases start gap-free.
                    if (full_q) begin
                        frame_d = buf_q;
                        full_d  = 1'b0;
                        state_d = START;
                    end else if (start) begin
                        frame_d = data;
                        full_d  = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:  tx = 1'b0;
            DATA:   tx = frame_q[idx_q];
`ifdef UART_TX_PARITY_EN
            PARITY: tx = ^frame_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign busy     = (state_q != IDLE) || full_q;
    assign done     = done_q;
    assign overflow = ovf_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            frame_q <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter P_CLKS_PER_BIT, default 868, CLK cycles per serial bit (100 MHz / 115200); legal range >= 2.
REQ-002 SHALL have parameter P_DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RSTn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request pulse (Debouncer out) to send data.
REQ-006 SHALL have port data  input  P_DATA_BITS  byte to send; sampled on the cycle start=1.
REQ-007 SHALL have port tx  output  1  serial line; idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is being shifted or one is pending.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a frame's stop bit completes.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when a start request is dropped.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 SHALL, in IDLE with start=1, latch data and enter START; tx=0 from the next cycle (latency 1).
REQ-013 SHALL hold every bit on tx for exactly P_CLKS_PER_BIT cycles via a bit-period counter cleared at each bit boundary.
REQ-014 SHALL send data LSB first in DATA, using a bit index counter from 0 to P_DATA_BITS-1.
REQ-015 SHALL drive tx=1 for the full STOP bit; frame length = (P_DATA_BITS+2) bit periods without parity.
REQ-016 SHALL pulse done for one cycle in the cycle after the last STOP cycle.
REQ-017 SHALL provide a one-entry pending buffer: start while not IDLE and buffer empty -> data stored, buffer full.
REQ-018 SHALL, when STOP completes with buffer full, enter START directly (zero idle cycles), empty the buffer, and pulse done in that same cycle.
REQ-019 SHALL, on start while not IDLE and buffer full, drop the request, keep the buffer unchanged, and pulse overflow next cycle.
REQ-020 SHALL treat start on the final STOP cycle as "not IDLE" (REQ-017/019 apply).
REQ-021 SHALL keep busy=1 whenever state != IDLE or buffer full; busy=0 in the cycle after STOP ends with buffer empty.
REQ-022 SHALL ignore changes on data except on accepted start cycles.

Reset
REQ-023 SHALL, while RSTn=0, force tx=1, busy=0, done=0, overflow=0, state IDLE, buffer empty, all counters 0.
REQ-024 SHALL abort any frame in progress on reset; no partial frame resumes after release.
REQ-025 SHALL accept start on the first rising edge after RSTn deasserts.

Configuration
REQ-026 SHALL, with macro UART_TX_PARITY_EN defined, insert PARITY state after DATA sending even parity (XOR of data bits) for one bit period; frame = P_DATA_BITS+3 bit periods.
REQ-027 SHALL, without UART_TX_PARITY_EN, have no parity state, logic or timing effect.

Structure
REQ-028 SHALL place FSM state encoding constants and the clog2 helper in shared package uart_pkg (existing clog2.vh content); counter widths derived via clog2.
REQ-029 SHALL instantiate sub-module uart_baud_gen (bit-period counter producing a one-cycle bit_tick, restartable by clear input).

Verification (bench uses P_CLKS_PER_BIT=4, P_DATA_BITS=8)
REQ-030 SHALL check single frame: start with data=8'hA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, done pulse at cycle 41, busy low at 41.
REQ-031 SHALL check back-to-back: start 8'h3C, then start 8'hC3 at cycle 10 -> second frame start bit begins cycle 41, no idle gap, done pulses at 41 and 81.
REQ-032 SHALL check overflow: starts 8'h01, 8'h02, 8'h03 at cycles 0, 5, 9 -> 8'h03 dropped, overflow pulse cycle 10, only 01 then 02 transmitted.
REQ-033 SHALL check reset mid-frame: RSTn low at cycle 17 of 8'hFF frame -> tx=1, busy=0 immediately; new start 8'h00 after release gives a clean full frame.
REQ-034 SHALL check parity with UART_TX_PARITY_EN: data=8'h07 -> parity bit 1 after bit 7, stop follows, done at cycle 45.
REQ-035 SHALL check boundary: start on final STOP cycle with buffer empty -> buffered, next frame starts without gap, no overflow.
